key_schedule: RTL and testbench

KEY_SCHEDULE -- requirements
Module: key_schedule

---
 rtl/des_pkg.sv | 61 ++++++
 rtl/key_schedule_pc2.sv | 20 ++
 rtl/key_schedule.sv | 136 +++++++++++++
 tb/tb_key_schedule.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// des_pkg: shared constants for the DES key schedule.
// Holds the PC-1/PC-2 selection tables, the per-round shift counts,
// the schedule FSM state type and the 28-bit rotate helpers.
// Table entries use FIPS 46-3 numbering: 1 is the MSB of the source.
package des_pkg;

    localparam int KEY_W    = 64;
    localparam int HALF_W   = 28;
    localparam int SUBKEY_W = 48;
    localparam int ROUNDS   = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ks_state_t;

    // PC-1: first 28 entries build C, last 28 build D
    localparam int PC1_TABLE [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: selects 48 of the 56 {C,D} bits
    localparam int PC2_TABLE [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Rotation applied before rounds 1..16. Decryption uses the same
    // counts as right rotations except that entry 0 becomes 0; that
    // difference is handled entirely at load time.
    localparam logic [1:0] SHIFT_TABLE [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [1:28] rotl28(input logic [1:28] x, input logic [1:0] n);
        logic [1:28] r;
        case (n)
            2'd1:    r = {x[2:28], x[1]};
            2'd2:    r = {x[3:28], x[1:2]};
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic [1:28] rotr28(input logic [1:28] x, input logic [1:0] n);
        logic [1:28] r;
        case (n)
            2'd1:    r = {x[28], x[1:27]};
            2'd2:    r = {x[27:28], x[1:26]};
            default: r = x;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_schedule_pc2.sv
// key_schedule_pc2: PC-2 permuted choice, purely combinational.
// Maps the 56-bit {C,D} register pair onto a 48-bit round subkey.
module key_schedule_pc2
    import des_pkg::*;
(
    input  logic [1:28] c,
    input  logic [1:28] d,
    output logic [1:48] subkey
);

    logic [1:56] cd;

    assign cd = {c, d};

    // Each subkey bit is a fixed wire pick from {C,D}
    for (genvar gi = 1; gi <= SUBKEY_W; gi++) begin : g_pc2
        assign subkey[gi] = cd[PC2_TABLE[gi-1]];
    end

endmodule

// File: rtl/key_schedule.sv
// key_schedule: DES round-key generator with a valid/ready output.
// Produces K1..K16 (or K16..K1 for decryption) one per handshake.
// Optional feature macro: DES_KEYSCHED_DECRYPT_EN enables decrypt order;
// without it the decrypt port is accepted but ignored.
// The round port is 4 bits wide, so round 16 reads back as 4'd0 while
// subkey_valid is high; the internal counter keeps the full value.
module key_schedule
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:64] key,
    input  logic        decrypt,
    output logic        busy,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [1:48] subkey,
    output logic [3:0]  round,
    output logic        done
);

    ks_state_t   state_q;
    logic [1:28] c_q;
    logic [1:28] d_q;
    logic [4:0]  rnd_q;
    logic        valid_q;
    logic        busy_q;
    logic        done_q;

    logic [1:56] pc1_cd;
    logic [1:28] load_c;
    logic [1:28] load_d;
    logic [1:28] step_c;
    logic [1:28] step_d;
    logic [1:0]  shift_amt;
    logic        handshake;
    logic        last_round;

    // PC-1 is pure wiring from the key; parity bits are never selected
    for (genvar gi = 1; gi <= 2*HALF_W; gi++) begin : g_pc1
        assign pc1_cd[gi] = key[PC1_TABLE[gi-1]];
    end

    assign handshake  = valid_q & subkey_ready;
    assign last_round = (rnd_q == 5'(ROUNDS));
    assign shift_amt  = SHIFT_TABLE[rnd_q[3:0]];

`ifdef DES_KEYSCHED_DECRYPT_EN
    logic dec_q;

    // Decrypt loads C0/D0 unrotated (K16 = K0 rotated 28) and walks back right
    always_comb begin
        load_c = decrypt ? pc1_cd[1:28]  : rotl28(pc1_cd[1:28], 2'd1);
        load_d = decrypt ? pc1_cd[29:56] : rotl28(pc1_cd[29:56], 2'd1);
        step_c = dec_q ? rotr28(c_q, shift_amt) : rotl28(c_q, shift_amt);
        step_d = dec_q ? rotr28(d_q, shift_amt) : rotl28(d_q, shift_amt);
    end

    // Direction is latched with start so later port changes cannot disturb a run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            dec_q <= decrypt;
        end
    end
`else
    logic unused_decrypt;

    assign unused_decrypt = decrypt;

    // Encrypt-only build: the first round's rotate-by-one is folded into the load
    always_comb begin
        load_c = rotl28(pc1_cd[1:28], 2'd1);
        load_d = rotl28(pc1_cd[29:56], 2'd1);
        step_c = rotl28(c_q, shift_amt);
        step_d = rotl28(d_q, shift_amt);
    end
`endif

    // Schedule FSM: load on start, advance one round per handshake, pulse done at the end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            rnd_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        c_q     <= load_c;
                        d_q     <= load_d;
                        rnd_q   <= 5'd1;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (handshake) begin
                        if (last_round) begin
                            state_q <= IDLE;
                            rnd_q   <= '0;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            c_q   <= step_c;
                            d_q   <= step_d;
                            rnd_q <= rnd_q + 5'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign subkey_valid = valid_q;
    assign done         = done_q;
    assign round        = rnd_q[3:0];

    key_schedule_pc2 u_pc2 (
        .c      (c_q),
        .d      (d_q),
        .subkey (subkey)
    );

endmodule

// File: tb/tb_key_schedule.sv
// tb_key_schedule: self-checking bench for key_schedule.
// Expected subkeys come from a behavioural DES key schedule computed with
// cumulative rotation counts; known FIPS vectors are checked as well.
// Honours DES_KEYSCHED_DECRYPT_EN when choosing the expected order.
module tb_key_schedule;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] key = '0;
    logic        decrypt = 1'b0;
    logic        subkey_ready = 1'b0;
    logic        busy;
    logic        subkey_valid;
    logic [47:0] subkey;
    logic [3:0]  round;
    logic        done;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] K0 = 64'h133457799BBCDFF1;

`ifdef DES_KEYSCHED_DECRYPT_EN
    localparam bit DEC_BUILT = 1'b1;
`else
    localparam bit DEC_BUILT = 1'b0;
`endif

    int pc1_t [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    int pc2_t [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    int shift_t [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    always #5 clk = ~clk;

    key_schedule dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .key          (key),
        .decrypt      (decrypt),
        .busy         (busy),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .round        (round),
        .done         (done)
    );

    function automatic logic [27:0] rotl(input logic [27:0] x, input int n);
        logic [27:0] a;
        logic [27:0] b;
        a = x << n;
        b = x >> (28 - n);
        return a | b;
    endfunction

    // Textbook schedule: Kr = PC2(C0 <<< S(r), D0 <<< S(r)), S(r) = sum of first r shifts
    function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int r);
        logic [55:0] cd;
        logic [55:0] cdr;
        logic [27:0] c;
        logic [27:0] d;
        logic [47:0] sk;
        int s;
        cd = '0;
        for (int i = 0; i < 56; i++)
            cd = {cd[54:0], ((k >> (64 - pc1_t[i])) & 64'd1) != 64'd0};
        s = 0;
        for (int j = 0; j < r; j++)
            s = s + shift_t[j];
        s = s % 28;
        c = rotl(cd[55:28], s);
        d = rotl(cd[27:0], s);
        cdr = {c, d};
        sk = '0;
        for (int i = 0; i < 48; i++)
            sk = {sk[46:0], ((cdr >> (56 - pc2_t[i])) & 56'd1) != 56'd0};
        return sk;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full schedule with optional stall, mid-run start poke and random ready
    task automatic run_schedule(input logic [63:0] k, input bit dec, input int stall_rnd,
                                input int stall_len, input int poke_rnd, input bit rand_ready,
                                input string tag);
        logic [47:0] exp_sk;
        int idx;
        int cycles;
        int stalled;
        bit hs;
        bit dec_eff;
        dec_eff = dec & DEC_BUILT;
        @(negedge clk);
        key = k;
        decrypt = dec;
        start = 1'b1;
        subkey_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        key = {$urandom, $urandom};
        decrypt = 1'($urandom_range(0, 1));
        idx = 1;
        cycles = 0;
        stalled = 0;
        while (idx <= 16 && cycles < 200) begin
            exp_sk = dec_eff ? ref_subkey(k, 17 - idx) : ref_subkey(k, idx);
            check_output($sformatf("%s_valid_r%0d", tag, idx), 64'(subkey_valid), 64'd1);
            check_output($sformatf("%s_busy_r%0d", tag, idx), 64'(busy), 64'd1);
            check_output($sformatf("%s_done_r%0d", tag, idx), 64'(done), 64'd0);
            check_output($sformatf("%s_round_r%0d", tag, idx), 64'(round), 64'(idx[3:0]));
            check_output($sformatf("%s_subkey_r%0d", tag, idx), 64'(subkey), 64'(exp_sk));
            if (k == K0 && !dec_eff && idx == 1)
                check_output({tag, "_fips_k1"}, 64'(subkey), 64'h1B02EFFC7072);
            if (k == K0 && !dec_eff && idx == 2)
                check_output({tag, "_fips_k2"}, 64'(subkey), 64'h79AED9DBC9E5);
            if (k == K0 && !dec_eff && idx == 16)
                check_output({tag, "_fips_k16"}, 64'(subkey), 64'hCB3D8B0E17F5);
            if (k == K0 && dec_eff && idx == 1)
                check_output({tag, "_fips_dec_first"}, 64'(subkey), 64'hCB3D8B0E17F5);
            if (k == K0 && dec_eff && idx == 16)
                check_output({tag, "_fips_dec_last"}, 64'(subkey), 64'h1B02EFFC7072);
            if (idx == stall_rnd && stalled < stall_len) begin
                subkey_ready = 1'b0;
                stalled++;
            end else if (rand_ready) begin
                subkey_ready = ($urandom_range(0, 3) != 0);
            end else begin
                subkey_ready = 1'b1;
            end
            start = (idx == poke_rnd) || (idx == 16);
            if (idx == poke_rnd) begin
                key = ~k;
                decrypt = ~dec;
            end
            hs = subkey_ready;
            @(negedge clk);
            start = 1'b0;
            cycles++;
            if (hs) idx++;
        end
        check_output({tag, "_completed"}, 64'(idx), 64'd17);
        if (stall_rnd == 0 && !rand_ready)
            check_output({tag, "_latency"}, 64'(cycles), 64'd16);
        check_output({tag, "_done_pulse"}, 64'(done), 64'd1);
        check_output({tag, "_valid_low"}, 64'(subkey_valid), 64'd0);
        check_output({tag, "_busy_low"}, 64'(busy), 64'd0);
        subkey_ready = 1'b1;
        @(negedge clk);
        check_output({tag, "_done_once"}, 64'(done), 64'd0);
        check_output({tag, "_final_start_ignored"}, 64'(subkey_valid), 64'd0);
    endtask

    // Watchdog so a stuck DUT still ends the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] key_schedule bench start, decrypt feature built = %0d", DEC_BUILT);

        // Reset state while rst_n is held low
        #12;
        check_output("reset_busy", 64'(busy), 64'd0);
        check_output("reset_valid", 64'(subkey_valid), 64'd0);
        check_output("reset_done", 64'(done), 64'd0);
        check_output("reset_round", 64'(round), 64'd0);
        check_output("reset_subkey", 64'(subkey), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Known vector, encrypt, ready always high
        run_schedule(K0, 1'b0, 0, 0, 0, 1'b0, "enc_k0");

        // Known vector with decrypt requested
        run_schedule(K0, 1'b1, 0, 0, 0, 1'b0, "dec_k0");

        // Backpressure for three cycles at round 5
        run_schedule(K0, 1'b0, 5, 3, 0, 1'b0, "stall_r5");

        // Start with a different key at round 8 must be ignored
        run_schedule(K0, 1'b0, 0, 0, 8, 1'b0, "poke_r8");

        // Asynchronous reset in the middle of round 10
        @(negedge clk);
        key = K0;
        decrypt = 1'b0;
        start = 1'b1;
        subkey_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check_output("pre_reset_round", 64'(round), 64'd10);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_busy", 64'(busy), 64'd0);
        check_output("async_valid", 64'(subkey_valid), 64'd0);
        check_output("async_done", 64'(done), 64'd0);
        check_output("async_round", 64'(round), 64'd0);
        check_output("async_subkey", 64'(subkey), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_schedule(K0, 1'b0, 0, 0, 0, 1'b0, "after_reset");

        // Random keys, directions and ready patterns
        for (int n = 0; n < 4; n++) begin
            run_schedule({$urandom, $urandom}, 1'($urandom_range(0, 1)), 0, 0, 0, 1'b1,
                         $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
